// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect_unit
// Description : Fetch-stage PC generator behind a gshare predictor. Steers
//               the fetch PC from the prediction, tracks predicted branches
//               in an in-order in-flight queue, and flushes and redirects
//               fetch when execute resolves the oldest branch to a different
//               next-PC. Emits the predictor update bundle for each resolved
//               branch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_unit #(
    parameter int PC_W  = 6,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_in,
    input  logic             if_is_branch,
    input  logic             bp_prediction,
    input  logic [PC_W-1:0]  bp_target,
    input  logic             ex_resolve_valid,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic [PC_W-1:0]  fetch_pc,
    output logic             fetch_valid,
    output logic             fetch_stall_out,
    output logic             flush,
    output logic             upd_branch,
    output logic [PC_W-1:0]  upd_pc,
    output logic [PC_W-1:0]  upd_target,
    output logic             upd_taken,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             protocol_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int QCNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [QCNT_W-1:0]  count_q, count_d;
    logic               flush_q, flush_d;
    logic               upd_branch_q, upd_branch_d;
    logic [PC_W-1:0]    upd_pc_q, upd_pc_d;
    logic [PC_W-1:0]    upd_target_q, upd_target_d;
    logic               upd_taken_q, upd_taken_d;
    logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;
    logic               perr_q, perr_d;

    // Queue storage: branch PC and the next-PC that fetch actually followed.
    logic [PC_W-1:0]    q_pc_q   [DEPTH];
    logic [PC_W-1:0]    q_next_q [DEPTH];

    logic               w_full;
    logic               w_adv;
    logic               w_push;
    logic               w_pop;
    logic               w_mispredict;
    logic [PC_W-1:0]    w_pc_plus1;
    logic [PC_W-1:0]    w_pred_next;
    logic [PC_W-1:0]    w_head_plus1;
    logic [PC_W-1:0]    w_actual_next;

    // Datapath decisions: advance, push/pop, and next-PC comparison.
    always_comb begin
        w_full        = (count_q == QCNT_W'(DEPTH));
        w_adv         = fetch_valid_q & ~stall_in & ~(if_is_branch & w_full);
        w_pc_plus1    = pc_q + PC_W'(1);
        w_pred_next   = bp_prediction ? bp_target : w_pc_plus1;
        w_pop         = ex_resolve_valid & (count_q != '0);
        w_head_plus1  = q_pc_q[head_q] + PC_W'(1);
        w_actual_next = ex_taken ? ex_target : w_head_plus1;
        // Only the next-PC matters: a "wrong" direction that lands on the
        // same address fetch already took costs nothing.
        w_mispredict  = w_pop & (w_actual_next != q_next_q[head_q]);
        // A redirect squashes everything younger, including this cycle's push.
        w_push        = w_adv & if_is_branch & ~w_mispredict;
    end

    // Next-state for FSM, PC, queue bookkeeping and status outputs.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        upd_branch_d  = w_pop;
        upd_pc_d      = upd_pc_q;
        upd_target_d  = upd_target_q;
        upd_taken_d   = upd_taken_q;
        mis_cnt_d     = mis_cnt_q;
        perr_d        = perr_q | (ex_resolve_valid & (count_q == '0));
        flush_d       = w_mispredict;

        case (state_q)
            ST_RUN:     if (w_mispredict) state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
        fetch_valid_d = (state_d == ST_RUN);

        if (w_pop) begin
            upd_pc_d     = q_pc_q[head_q];
            upd_target_d = ex_target;
            upd_taken_d  = ex_taken;
        end

        if (w_mispredict) begin
            pc_d    = w_actual_next;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end else begin
            if (w_adv) pc_d = (if_is_branch & bp_prediction) ? bp_target : w_pc_plus1;
            if (w_push) tail_d = tail_q + PTR_W'(1);
            if (w_pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + QCNT_W'(w_push) - QCNT_W'(w_pop);
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            fetch_valid_q <= 1'b0;
            pc_q          <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            flush_q       <= 1'b0;
            upd_branch_q  <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
            upd_taken_q   <= 1'b0;
            mis_cnt_q     <= '0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            pc_q          <= pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            flush_q       <= flush_d;
            upd_branch_q  <= upd_branch_d;
            upd_pc_q      <= upd_pc_d;
            upd_target_q  <= upd_target_d;
            upd_taken_q   <= upd_taken_d;
            mis_cnt_q     <= mis_cnt_d;
            perr_q        <= perr_d;
        end
    end

    // Queue payload write; validity is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            q_pc_q[tail_q]   <= pc_q;
            q_next_q[tail_q] <= w_pred_next;
        end
    end

    assign fetch_pc         = pc_q;
    assign fetch_valid      = fetch_valid_q;
    assign fetch_stall_out  = fetch_valid_q & if_is_branch & w_full;
    assign flush            = flush_q;
    assign upd_branch       = upd_branch_q;
    assign upd_pc           = upd_pc_q;
    assign upd_target       = upd_target_q;
    assign upd_taken        = upd_taken_q;
    assign mispredict_count = mis_cnt_q;
    assign protocol_err     = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_redirect_unit
// Description : Directed self-checking bench for fetch_redirect_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_unit;

    logic       clk;
    logic       reset;
    logic       stall_in;
    logic       if_is_branch;
    logic       bp_prediction;
    logic [5:0] bp_target;
    logic       ex_resolve_valid;
    logic       ex_taken;
    logic [5:0] ex_target;
    logic [5:0] fetch_pc;
    logic       fetch_valid;
    logic       fetch_stall_out;
    logic       flush;
    logic       upd_branch;
    logic [5:0] upd_pc;
    logic [5:0] upd_target;
    logic       upd_taken;
    logic [7:0] mispredict_count;
    logic       protocol_err;

    int n_checks = 0;
    int n_errors = 0;

    fetch_redirect_unit #(.PC_W(6), .DEPTH(4), .CNT_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (stall_in),
        .if_is_branch     (if_is_branch),
        .bp_prediction    (bp_prediction),
        .bp_target        (bp_target),
        .ex_resolve_valid (ex_resolve_valid),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .fetch_pc         (fetch_pc),
        .fetch_valid      (fetch_valid),
        .fetch_stall_out  (fetch_stall_out),
        .flush            (flush),
        .upd_branch       (upd_branch),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .mispredict_count (mispredict_count),
        .protocol_err     (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        stall_in         = 1'b0;
        if_is_branch     = 1'b0;
        bp_prediction    = 1'b0;
        bp_target        = '0;
        ex_resolve_valid = 1'b0;
        ex_taken         = 1'b0;
        ex_target        = '0;
    endtask

    // Reset, release off-edge, then one edge so fetch_valid=1 at pc=0.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        logic [5:0] exp_pc;

        // ---------------- reset state ----------------
        clear_inputs();
        reset = 1'b0;
        #3;
        check_value("rst_pc", fetch_pc, 0);
        check_value("rst_valid", fetch_valid, 0);
        check_value("rst_flush", flush, 0);
        check_value("rst_upd", upd_branch, 0);
        check_value("rst_mcnt", mispredict_count, 0);
        check_value("rst_perr", protocol_err, 0);
        check_value("rst_stall", fetch_stall_out, 0);

        // ---------------- sequential fetch with wrap ----------------
        #9;
        reset = 1'b1;
        tick();
        check_value("seq_valid1", fetch_valid, 1);
        check_value("seq_pc0", fetch_pc, 0);
        exp_pc = 6'd0;
        for (int i = 0; i < 70; i++) begin
            tick();
            exp_pc = exp_pc + 6'd1;
            check_value("seq_pc", fetch_pc, exp_pc);
            check_value("seq_flush", flush, 0);
        end
        check_value("seq_wrap_pc", fetch_pc, 6);

        // stall holds PC
        stall_in = 1'b1;
        tick();
        check_value("stall_hold", fetch_pc, 6);
        stall_in = 1'b0;
        tick();
        check_value("stall_release", fetch_pc, 7);

        // ---------------- correct taken prediction ----------------
        do_reset();
        repeat (5) tick();
        check_value("tk_pc5", fetch_pc, 5);
        if_is_branch = 1'b1; bp_prediction = 1'b1; bp_target = 6'd20;
        tick();
        check_value("tk_redirect", fetch_pc, 20);
        clear_inputs();
        tick();
        check_value("tk_pc21", fetch_pc, 21);
        ex_resolve_valid = 1'b1; ex_taken = 1'b1; ex_target = 6'd20;
        tick();
        clear_inputs();
        check_value("tk_upd", upd_branch, 1);
        check_value("tk_upd_pc", upd_pc, 5);
        check_value("tk_upd_taken", upd_taken, 1);
        check_value("tk_upd_tgt", upd_target, 20);
        check_value("tk_noflush", flush, 0);
        check_value("tk_pc22", fetch_pc, 22);
        tick();
        check_value("tk_upd_drop", upd_branch, 0);
        // queue now empty: another resolve is a protocol error
        ex_resolve_valid = 1'b1;
        tick();
        clear_inputs();
        check_value("perr_set", protocol_err, 1);
        check_value("perr_no_upd", upd_branch, 0);
        repeat (3) tick();
        check_value("perr_sticky", protocol_err, 1);

        // ---------------- mispredict ----------------
        do_reset();
        repeat (8) tick();
        check_value("mp_pc8", fetch_pc, 8);
        if_is_branch = 1'b1; bp_prediction = 1'b0; bp_target = 6'd50;
        tick();
        check_value("mp_pc9", fetch_pc, 9);
        clear_inputs();
        ex_resolve_valid = 1'b1; ex_taken = 1'b1; ex_target = 6'd30;
        tick();
        clear_inputs();
        check_value("mp_flush", flush, 1);
        check_value("mp_pc30", fetch_pc, 30);
        check_value("mp_valid0", fetch_valid, 0);
        check_value("mp_cnt", mispredict_count, 1);
        check_value("mp_upd_pc", upd_pc, 8);
        tick();
        check_value("mp_flush_once", flush, 0);
        check_value("mp_valid1", fetch_valid, 1);
        check_value("mp_pc_hold", fetch_pc, 30);
        tick();
        check_value("mp_pc31", fetch_pc, 31);
        ex_resolve_valid = 1'b1;
        tick();
        clear_inputs();
        check_value("mp_q_empty", protocol_err, 1);

        // ---------------- queue full ----------------
        do_reset();
        if_is_branch = 1'b1; bp_prediction = 1'b0;
        repeat (4) tick();
        check_value("qf_pc4", fetch_pc, 4);
        #1;
        check_value("qf_stall", fetch_stall_out, 1);
        tick();
        check_value("qf_pc_hold", fetch_pc, 4);
        check_value("qf_stall2", fetch_stall_out, 1);
        ex_resolve_valid = 1'b1; ex_taken = 1'b0; ex_target = 6'd0;
        #1;
        check_value("qf_stall_prepop", fetch_stall_out, 1);
        tick();
        ex_resolve_valid = 1'b0;
        check_value("qf_pc_hold2", fetch_pc, 4);
        check_value("qf_upd_pc", upd_pc, 0);
        check_value("qf_upd_taken", upd_taken, 0);
        check_value("qf_noflush", flush, 0);
        #1;
        check_value("qf_stall_clr", fetch_stall_out, 0);
        tick();
        check_value("qf_push_pc5", fetch_pc, 5);
        check_value("qf_stall_again", fetch_stall_out, 1);
        check_value("qf_mcnt", mispredict_count, 0);
        clear_inputs();

        // ---------------- benign direction mismatch ----------------
        do_reset();
        repeat (12) tick();
        check_value("bn_pc12", fetch_pc, 12);
        if_is_branch = 1'b1; bp_prediction = 1'b0;
        tick();
        clear_inputs();
        ex_resolve_valid = 1'b1; ex_taken = 1'b1; ex_target = 6'd13;
        tick();
        clear_inputs();
        check_value("bn_noflush", flush, 0);
        check_value("bn_upd", upd_branch, 1);
        check_value("bn_upd_taken", upd_taken, 1);
        check_value("bn_upd_pc", upd_pc, 12);
        check_value("bn_upd_tgt", upd_target, 13);
        check_value("bn_pc14", fetch_pc, 14);
        check_value("bn_mcnt", mispredict_count, 0);
        check_value("bn_perr0", protocol_err, 0);
        ex_resolve_valid = 1'b1;
        tick();
        clear_inputs();
        check_value("bn_q_empty", protocol_err, 1);

        // ---------------- reset mid-run ----------------
        do_reset();
        ex_resolve_valid = 1'b1;
        tick();
        clear_inputs();
        check_value("mr_perr", protocol_err, 1);
        check_value("mr_pc1", fetch_pc, 1);
        if_is_branch = 1'b1; bp_prediction = 1'b0;
        repeat (3) tick();
        clear_inputs();
        check_value("mr_pc4", fetch_pc, 4);
        #1;
        reset = 1'b0;
        #1;
        check_value("mr_pc", fetch_pc, 0);
        check_value("mr_valid", fetch_valid, 0);
        check_value("mr_perr0", protocol_err, 0);
        check_value("mr_flush", flush, 0);
        check_value("mr_upd", upd_branch, 0);
        check_value("mr_mcnt", mispredict_count, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick();
        check_value("mr_valid1", fetch_valid, 1);
        check_value("mr_noflush", flush, 0);
        ex_resolve_valid = 1'b1;
        tick();
        clear_inputs();
        check_value("mr_q_lost", protocol_err, 1);

        // ---------------- mispredict counter saturation ----------------
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if_is_branch = 1'b1; bp_prediction = 1'b0;
            tick();
            clear_inputs();
            ex_resolve_valid = 1'b1; ex_taken = 1'b1; ex_target = 6'd40;
            tick();
            clear_inputs();
            tick();
        end
        check_value("sat_cnt", mispredict_count, 255);
        check_value("sat_pc", fetch_pc, 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-stage PC generator sitting directly downstream of the gshare predictor.
- Drives the fetch PC into the predictor and selects next PC from the predictor's prediction/predicted_target.
- Records every predicted branch in an in-order in-flight queue; when execute resolves the oldest branch, compares actual vs predicted next-PC, and on mismatch flushes and redirects fetch.
- Emits the predictor update bundle (branch, pc, taken, target) for each resolved branch.

Parameters:
- PC_W, 6, PC width; PC arithmetic wraps mod 2^PC_W
- DEPTH, 4, in-flight branch queue entries (power of 2, >=2)
- CNT_W, 8, width of mispredict counter

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (reset=0 clears all state immediately)
- stall_in  in  1  backend stall; PC holds, no queue push
- if_is_branch  in  1  predecode: instruction at fetch_pc is a branch
- bp_prediction  in  1  predictor taken/not-taken for fetch_pc
- bp_target  in  PC_W  predictor target for fetch_pc
- ex_resolve_valid  in  1  execute resolves oldest in-flight branch this cycle
- ex_taken  in  1  actual outcome
- ex_target  in  PC_W  actual taken target
- fetch_pc  out  PC_W  current fetch PC, also predictor lookup PC
- fetch_valid  out  1  fetch_pc is a valid fetch this cycle
- fetch_stall_out  out  1  fetch held because queue full
- flush  out  1  one-cycle pulse: squash all younger instructions
- upd_branch  out  1  predictor update strobe
- upd_pc / upd_target  out  PC_W  resolved branch PC / actual target
- upd_taken  out  1  actual outcome
- mispredict_count  out  CNT_W  saturating mispredict counter
- protocol_err  out  1  sticky: resolve received with empty queue

Behaviour:
- Reset (async, reset=0): fetch_pc=0, fetch_valid=0, flush=0, fetch_stall_out=0, upd_*=0, mispredict_count=0, protocol_err=0, queue empty (head=tail=count=0), FSM=RUN. First edge after release: fetch_valid=1.
- FSM states: RUN, RECOVER. RUN->RECOVER on mispredict; RECOVER->RUN unconditionally next cycle. fetch_valid=1 in RUN, 0 in RECOVER.
- Advance condition (RUN): adv = fetch_valid & ~stall_in & ~(if_is_branch & full).
- fetch_stall_out = fetch_valid & if_is_branch & full (combinational).
- Next PC when adv: if_is_branch & bp_prediction -> bp_target, else fetch_pc+1 (wraps 63->0). Not adv: hold.
- Push when adv & if_is_branch: entry {fetch_pc, bp_prediction, pred_next = bp_prediction ? bp_target : fetch_pc+1}.
- Pop when ex_resolve_valid & count>0: oldest entry E. actual_next = ex_taken ? ex_target : E.pc+1. mispredict = (actual_next != E.pred_next). Direction mismatch with equal next-PC (taken target == pc+1) is NOT a mispredict.
- Update outputs registered, 1-cycle latency after pop: upd_branch=1, upd_pc=E.pc, upd_taken=ex_taken, upd_target=ex_target; upd_branch=0 otherwise.
- On mispredict (registered, same edge): flush=1 for exactly one cycle, fetch_pc<=actual_next, queue cleared (count=0), any simultaneous push discarded, FSM->RECOVER, mispredict_count+=1 saturating at all-ones. Mispredict overrides stall_in.
- Simultaneous push and non-mispredicting pop: both occur, count unchanged; legal when full (no fetch stall needed if pop same cycle; full is evaluated pre-pop, so stall still asserts — conservative, required).
- ex_resolve_valid with count=0: no pop, no update, protocol_err<=1 (sticky until reset).
- RECOVER: no push, PC holds, resolves treated as above (queue empty -> protocol_err).
- count in 0..DEPTH; full=(count==DEPTH); pointers wrap mod DEPTH.
- Reset asserted mid-operation: all state cleared asynchronously, in-flight entries lost, no flush pulse generated.

Test Plan:
- Sequential fetch: release reset, no branches, no stall, 70 cycles -> fetch_pc 0,1,...,63,0,...; fetch_valid=1 from cycle 1; flush never asserts.
- Correct taken prediction: at pc=5 is_branch=1, pred=1, target=20 -> next fetch_pc=20; later resolve taken, target 20 -> upd_branch=1, upd_pc=5, upd_taken=1, no flush, count 1->0.
- Mispredict: pc=8 branch predicted not-taken (next 9), resolve ex_taken=1, ex_target=30 -> flush=1 one cycle, fetch_pc=30, fetch_valid=0 one cycle, queue empty, mispredict_count=1.
- Queue full: push 4 unresolved branches, 5th branch at fetch -> fetch_stall_out=1, fetch_pc held; resolve one (correct) -> next cycle push accepted, stall clears.
- Benign direction mismatch: branch pc=12, predicted not-taken, resolve taken with ex_target=13 -> no flush, upd_taken=1, count decremented.
- Error/reset: resolve with empty queue -> protocol_err=1 sticky; assert reset=0 mid-run with 3 entries -> all outputs to reset values immediately, protocol_err=0.
